leds_sequencer: RTL and testbench

Avalon-MM controller that drives the 8-bit LED output register of the digital watch. Software programs a pattern, a mode (static, blink, chase left, chase right) and a step period through a slave port. The block then autonomously generates LED frames and writes each one to the LED register through a master port. CPU traffic to the LEDs is reduced to configuration writes.

---
 rtl/leds_sequencer_if.sv | 27 ++
 rtl/leds_sequencer.sv | 146 ++++++++++++++
 tb/tb_leds_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/leds_sequencer_if.sv
// Avalon buses of the LED sequencer: config slave port (s1) and LED-register master port (m1).
// The "slave" modport is the sequencer's view, "master" is the system/CPU side.
interface leds_sequencer_if;
  logic [1:0]  avs_s1_address;
  logic        avs_s1_write;
  logic [15:0] avs_s1_writedata;
  logic        avs_s1_read;
  logic [15:0] avs_s1_readdata;
  logic [3:0]  avm_m1_address;
  logic        avm_m1_write;
  logic [7:0]  avm_m1_writedata;
  logic        avm_m1_waitrequest;

  modport slave (
    input  avs_s1_address, avs_s1_write, avs_s1_writedata, avs_s1_read,
    output avs_s1_readdata,
    output avm_m1_address, avm_m1_write, avm_m1_writedata,
    input  avm_m1_waitrequest
  );

  modport master (
    output avs_s1_address, avs_s1_write, avs_s1_writedata, avs_s1_read,
    input  avs_s1_readdata,
    input  avm_m1_address, avm_m1_write, avm_m1_writedata,
    output avm_m1_waitrequest
  );
endinterface

// File: rtl/leds_sequencer.sv
// LED frame sequencer: config/step event in cycle N -> LED write in N+1; zero-wait-state readback.
// Waitrequest holds the write stable; events arriving meanwhile collapse into one pending frame.
module leds_sequencer #(
  parameter int TICK_W = 16
) (
  input  logic                    csi_clk,
  input  logic                    csi_reset_n,
  leds_sequencer_if.slave         bus
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  logic              en_q;
  logic [1:0]        mode_q;
  logic [7:0]        pattern_q;
  logic [TICK_W-1:0] period_q;
  logic [TICK_W-1:0] cnt_q;
  logic [7:0]        frame_q;
  logic              phase_q;
  logic              overrun_q;
  logic              pend_q;
  logic [7:0]        pend_dat_q;
  state_t            state_q;
  logic              wr_vld_q;
  logic [7:0]        wr_dat_q;
  logic [15:0]       rd_dat;

  logic       wr_ctrl, wr_pat, wr_per, wr_sts, cfg_wr;
  logic       running, step, new_en, dis_ev, reload, ev_vld;
  logic [7:0] new_pat, step_frame, ev_dat;

  assign wr_ctrl = bus.avs_s1_write && (bus.avs_s1_address == 2'd0);
  assign wr_pat  = bus.avs_s1_write && (bus.avs_s1_address == 2'd1);
  assign wr_per  = bus.avs_s1_write && (bus.avs_s1_address == 2'd2);
  assign wr_sts  = bus.avs_s1_write && (bus.avs_s1_address == 2'd3);
  assign cfg_wr  = wr_ctrl || wr_pat || wr_per;

  // Any config write in the same cycle discards a step (and never counts as overrun).
  assign running = en_q && (mode_q != 2'd0);
  assign step    = running && (cnt_q == period_q) && !cfg_wr;

  assign new_en  = wr_ctrl ? bus.avs_s1_writedata[0] : en_q;
  assign new_pat = wr_pat ? bus.avs_s1_writedata[7:0] : pattern_q;
  assign dis_ev  = wr_ctrl && en_q && !bus.avs_s1_writedata[0];
  assign reload  = (wr_ctrl || wr_pat) && !dis_ev;

  always_comb begin
    step_frame = frame_q;
    case (mode_q)
      2'd1:    step_frame = phase_q ? 8'h00 : pattern_q;
      2'd2:    step_frame = {frame_q[6:0], frame_q[7]};
      2'd3:    step_frame = {frame_q[0], frame_q[7:1]};
      default: step_frame = frame_q;
    endcase
  end

  assign ev_vld = (reload && new_en) || dis_ev || step;
  assign ev_dat = dis_ev ? 8'h00 : (reload ? new_pat : step_frame);

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      en_q      <= 1'b0;
      mode_q    <= 2'd0;
      pattern_q <= 8'h00;
      period_q  <= '1;
      cnt_q     <= '0;
      frame_q   <= 8'h00;
      phase_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (wr_ctrl) {mode_q, en_q} <= bus.avs_s1_writedata[2:0];
      if (wr_pat)  pattern_q <= bus.avs_s1_writedata[7:0];
      if (wr_per)  period_q  <= bus.avs_s1_writedata[TICK_W-1:0];

      if (cfg_wr || !running || (cnt_q == period_q)) cnt_q <= '0;
      else                                           cnt_q <= cnt_q + TICK_W'(1);

      // Disabling leaves the frame untouched so STATUS still shows the last frame.
      if (reload) begin
        frame_q <= new_pat;
        phase_q <= 1'b1;
      end else if (step) begin
        frame_q <= step_frame;
        phase_q <= ~phase_q;
      end

      if (step && (state_q == S_WRITE))               overrun_q <= 1'b1;
      else if (wr_sts && bus.avs_s1_writedata[1])     overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q    <= S_IDLE;
      wr_vld_q   <= 1'b0;
      wr_dat_q   <= 8'h00;
      pend_q     <= 1'b0;
      pend_dat_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Same-cycle events bypass the pending flag to keep N+1 latency.
          if (ev_vld || pend_q) begin
            state_q  <= S_WRITE;
            wr_vld_q <= 1'b1;
            wr_dat_q <= ev_vld ? ev_dat : pend_dat_q;
            pend_q   <= 1'b0;
          end
        end
        S_WRITE: begin
          if (ev_vld) begin
            pend_q     <= 1'b1;
            pend_dat_q <= ev_dat;
          end
          if (!bus.avm_m1_waitrequest) begin
            state_q  <= S_IDLE;
            wr_vld_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_dat = '0;
    if (bus.avs_s1_read) begin
      case (bus.avs_s1_address)
        2'd0: rd_dat[2:0] = {mode_q, en_q};
        2'd1: rd_dat[7:0] = pattern_q;
        2'd2: rd_dat[TICK_W-1:0] = period_q;
        default: begin
          rd_dat[0]    = wr_vld_q || pend_q;
          rd_dat[1]    = overrun_q;
          rd_dat[10:3] = frame_q;
        end
      endcase
    end
  end

  assign bus.avs_s1_readdata  = rd_dat;
  assign bus.avm_m1_address   = 4'd0;
  assign bus.avm_m1_write     = wr_vld_q;
  assign bus.avm_m1_writedata = wr_dat_q;

endmodule

// File: tb/tb_leds_sequencer.sv
// Bench for leds_sequencer: expected LED frames are queued as stimulus is applied
// and popped by a bus monitor on each completed master write.
module tb_leds_sequencer;

  logic csi_clk = 1'b0;
  logic csi_reset_n = 1'b0;

  leds_sequencer_if bus();

  leds_sequencer #(.TICK_W(16)) dut (
    .csi_clk     (csi_clk),
    .csi_reset_n (csi_reset_n),
    .bus         (bus)
  );

  always #5 csi_clk = ~csi_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_wr  = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int         wr_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge csi_clk) cyc <= cyc + 1;

  // Completed transfer = write high with waitrequest low, sampled mid-low-phase.
  always @(negedge csi_clk) begin
    #1;
    if (csi_reset_n && bus.avm_m1_write && !bus.avm_m1_waitrequest) begin
      n_wr++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() != 0) chk("wr_dat", {24'h0, bus.avm_m1_writedata}, {24'h0, exp_q.pop_front()});
      else                   chk("wr_extra_q_depth", exp_q.size(), 1);
    end
  end

  task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge csi_clk);
    bus.avs_s1_address   = a;
    bus.avs_s1_writedata = d;
    bus.avs_s1_write     = 1'b1;
    @(negedge csi_clk);
    bus.avs_s1_write     = 1'b0;
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge csi_clk);
    bus.avs_s1_address = a;
    bus.avs_s1_read    = 1'b1;
    #1;
    d = bus.avs_s1_readdata;
    bus.avs_s1_read    = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    int k = 0;
    while (n_wr < target && k < budget) begin
      @(negedge csi_clk);
      k++;
    end
    chk(tag, n_wr, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_wr=%0d", n_wr);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [7:0]  v;
    int base, bad;

    bus.avs_s1_address     = 2'd0;
    bus.avs_s1_write       = 1'b0;
    bus.avs_s1_writedata   = 16'h0;
    bus.avs_s1_read        = 1'b0;
    bus.avm_m1_waitrequest = 1'b0;

    repeat (3) @(negedge csi_clk);
    csi_reset_n = 1'b1;

    // Reset values and quiet idle
    chk("rst_wr", bus.avm_m1_write, 0);
    chk("rst_wdat", bus.avm_m1_writedata, 0);
    chk("rst_addr", bus.avm_m1_address, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge csi_clk);
      if (bus.avm_m1_write !== 1'b0) bad++;
    end
    chk("idle_wr_high_cycles", bad, 0);
    chk("idle_nwr", n_wr, 0);
    cfg_rd(2'd3, rd); chk("rst_status", rd, 16'h0000);
    cfg_rd(2'd2, rd); chk("rst_period", rd, 16'hFFFF);
    cfg_rd(2'd0, rd); chk("rst_ctrl", rd, 16'h0000);
    cfg_rd(2'd1, rd); chk("rst_pattern", rd, 16'h0000);

    // Static: one write per config write while enabled, nothing else
    cfg_wr(2'd1, 16'h00A5);
    exp_q.push_back(8'hA5);
    cfg_wr(2'd0, 16'h0001);
    chk("lat_wr", bus.avm_m1_write, 1);
    chk("lat_dat", bus.avm_m1_writedata, 8'hA5);
    @(negedge csi_clk);
    chk("one_cycle_wr", bus.avm_m1_write, 0);
    exp_q.push_back(8'h3C);
    cfg_wr(2'd1, 16'h003C);
    repeat (1000) @(negedge csi_clk);
    chk("static_nwr", n_wr, 2);
    cfg_rd(2'd1, rd); chk("pattern_rb", rd, 16'h003C);
    cfg_rd(2'd0, rd); chk("ctrl_rb", rd, 16'h0001);

    // Disable from static produces a single 00 write
    exp_q.push_back(8'h00);
    cfg_wr(2'd0, 16'h0000);
    repeat (5) @(negedge csi_clk);
    chk("static_dis_nwr", n_wr, 3);

    // Chase-left with PERIOD=3: rotating frames 4 cycles apart, wrapping 80 -> 01
    cfg_wr(2'd1, 16'h0001);
    cfg_wr(2'd2, 16'h0003);
    base = n_wr;
    wr_cyc_q.delete();
    v = 8'h01;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(v);
      v = {v[6:0], v[7]};
    end
    cfg_wr(2'd0, 16'h0005);
    wait_wr(base + 10, 200, "chase_nwr");
    if (wr_cyc_q.size() >= 10)
      for (int i = 1; i < 10; i++) chk("chase_gap", wr_cyc_q[i] - wr_cyc_q[i-1], 4);

    exp_q.push_back(8'h00);
    cfg_wr(2'd0, 16'h0000);
    chk("dis_lat_wr", bus.avm_m1_write, 1);
    chk("dis_dat", bus.avm_m1_writedata, 8'h00);
    repeat (500) @(negedge csi_clk);
    chk("dis_quiet_nwr", n_wr, base + 11);
    cfg_rd(2'd3, rd); chk("dis_status_frame", rd, 16'h0010);

    // Blink with waitrequest stuck high for 25 cycles
    cfg_wr(2'd1, 16'h000F);
    cfg_wr(2'd2, 16'h0009);
    bus.avm_m1_waitrequest = 1'b1;
    base = n_wr;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h0F);
    cfg_wr(2'd0, 16'h0003);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.avm_m1_write !== 1'b1 || bus.avm_m1_writedata !== 8'h0F) bad++;
      if (i == 22) begin
        bus.avs_s1_address   = 2'd2;
        bus.avs_s1_writedata = 16'hFFFF;
        bus.avs_s1_write     = 1'b1;
      end else begin
        bus.avs_s1_write     = 1'b0;
      end
      @(negedge csi_clk);
    end
    chk("wait_stable_bad", bad, 0);
    chk("wait_nwr", n_wr, base);
    bus.avm_m1_waitrequest = 1'b0;
    wait_wr(base + 2, 20, "blink_nwr");
    cfg_rd(2'd3, rd); chk("blink_status_ovr", rd, 16'h007A);
    cfg_wr(2'd3, 16'h0002);
    cfg_rd(2'd3, rd); chk("ovr_clear", rd, 16'h0078);
    exp_q.push_back(8'h00);
    cfg_wr(2'd0, 16'h0000);
    repeat (500) @(negedge csi_clk);
    chk("blink_dis_nwr", n_wr, base + 3);

    // Reset asserted while a write is held
    cfg_wr(2'd1, 16'h005A);
    bus.avm_m1_waitrequest = 1'b1;
    base = n_wr;
    cfg_wr(2'd0, 16'h0001);
    chk("mid_wr", bus.avm_m1_write, 1);
    #2 csi_reset_n = 1'b0;
    #1;
    chk("async_rst_wr", bus.avm_m1_write, 0);
    chk("async_rst_wdat", bus.avm_m1_writedata, 0);
    @(negedge csi_clk);
    @(negedge csi_clk);
    csi_reset_n = 1'b1;
    bus.avm_m1_waitrequest = 1'b0;
    cfg_rd(2'd0, rd); chk("rst2_ctrl", rd, 16'h0000);
    cfg_rd(2'd1, rd); chk("rst2_pattern", rd, 16'h0000);
    cfg_rd(2'd2, rd); chk("rst2_period", rd, 16'hFFFF);
    cfg_rd(2'd3, rd); chk("rst2_status", rd, 16'h0000);
    repeat (50) @(negedge csi_clk);
    chk("rst2_nwr", n_wr, base);

    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
